// File: rtl/ph_fifo_bank_if.sv
// Parasite-write / host-read bus bundle for the ph_fifo_bank register bank.
// The master side drives writes, pops, selects, mode and flush; the slave side is the bank.
interface ph_fifo_bank_if #(
    parameter int NCHAN = 4,
    parameter int WIDTH = 8,
    parameter int CW    = 2
);
    logic                  p_wr;
    logic [NCHAN-1:0]      p_sel;
    logic [WIDTH-1:0]      p_data;
    logic                  h_rd;
    logic [NCHAN-1:0]      h_sel;
    logic                  one_byte_mode;
    logic [NCHAN-1:0]      flush;
    logic [WIDTH-1:0]      h_data;
    logic [NCHAN-1:0]      h_data_available;
    logic                  h_zero_bytes_available;
    logic [NCHAN-1:0]      p_full;
    logic [NCHAN-1:0]      p_overflow;
    logic [NCHAN*CW-1:0]   h_count;

    modport master (
        output p_wr, p_sel, p_data, h_rd, h_sel, one_byte_mode, flush,
        input  h_data, h_data_available, h_zero_bytes_available, p_full, p_overflow, h_count
    );

    modport slave (
        input  p_wr, p_sel, p_data, h_rd, h_sel, one_byte_mode, flush,
        output h_data, h_data_available, h_zero_bytes_available, p_full, p_overflow, h_count
    );
endinterface

// File: rtl/ph_fifo_bank.sv
// Parasite-to-host bank of NCHAN independent first-word-fall-through FIFOs with
// fill counts, sticky overflow, flush, and one-byte/two-byte mode on channel ZB_CHAN.
module ph_fifo_bank #(
    parameter int NCHAN   = 4,
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 2,
    parameter int CW      = 2,
    parameter int ZB_CHAN = 2
) (
    input  logic            h_phi2,
    input  logic            h_rst_b,
    ph_fifo_bank_if.slave   bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] TWO_C   = CW'(2);
    localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

    logic                 mode_q;
    logic                 mode_change;
    logic [NCHAN-1:0]     wr_sel;
    logic [NCHAN-1:0]     rd_sel;
    logic [CW-1:0]        count [NCHAN];
    logic [WIDTH-1:0]     head  [NCHAN];

    // Multi-hot selects collapse to their lowest set bit.
    assign wr_sel      = bus.p_sel & (~bus.p_sel + NCHAN'(1));
    assign rd_sel      = bus.h_sel & (~bus.h_sel + NCHAN'(1));
    assign mode_change = bus.one_byte_mode != mode_q;

    always_ff @(posedge h_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            mode_q <= 1'b0;
        end else begin
            mode_q <= bus.one_byte_mode;
        end
    end

    for (genvar ch = 0; ch < NCHAN; ch++) begin : g_chan
        localparam bit IS_ZB = (ch == ZB_CHAN);

        logic [WIDTH-1:0] mem [DEPTH];
        logic [PW-1:0]    wptr;
        logic [PW-1:0]    rptr;
        logic [CW-1:0]    cnt;
        logic [CW-1:0]    cap;
        logic             full;
        logic             clr;
        logic             do_pop;
        logic             do_push;
        logic             ovf;

        assign cap  = (IS_ZB && bus.one_byte_mode) ? ONE_C : DEPTH_C;
        assign full = cnt >= cap;
        assign clr  = bus.flush[ch] | (IS_ZB & mode_change);

        // A pop on a full channel frees the slot that a same-cycle push then takes.
        assign do_pop  = bus.h_rd & rd_sel[ch] & (cnt != '0) & ~clr;
        assign do_push = bus.p_wr & wr_sel[ch] & (~full | do_pop) & ~clr;

        always_ff @(posedge h_phi2 or negedge h_rst_b) begin
            if (!h_rst_b) begin
                wptr <= '0;
                rptr <= '0;
                cnt  <= '0;
                ovf  <= 1'b0;
            end else if (clr) begin
                wptr <= '0;
                rptr <= '0;
                cnt  <= '0;
                ovf  <= 1'b0;
            end else begin
                if (do_push) begin
                    wptr <= (wptr == LAST_P) ? '0 : wptr + PW'(1);
                end
                if (do_pop) begin
                    rptr <= (rptr == LAST_P) ? '0 : rptr + PW'(1);
                end
                if (do_push && !do_pop) begin
                    cnt <= cnt + ONE_C;
                end else if (do_pop && !do_push) begin
                    cnt <= cnt - ONE_C;
                end
                if (bus.p_wr && wr_sel[ch] && !do_push) begin
                    ovf <= 1'b1;
                end
            end
        end

        always_ff @(posedge h_phi2) begin
            if (h_rst_b && do_push) begin
                mem[wptr] <= bus.p_data;
            end
        end

        assign head[ch]  = mem[rptr];
        assign count[ch] = cnt;

        assign bus.h_count[ch*CW +: CW] = cnt;
        assign bus.p_full[ch]           = full;
        assign bus.p_overflow[ch]       = ovf;
        // In two-byte mode the ZB channel reports ready only once a full pair is held.
        assign bus.h_data_available[ch] = IS_ZB ? (bus.one_byte_mode ? (cnt >= ONE_C) : (cnt >= TWO_C))
                                                : (cnt != '0);
    end

    assign bus.h_zero_bytes_available = (count[ZB_CHAN] == '0);

    always_comb begin
        bus.h_data = '0;
        for (int i = 0; i < NCHAN; i++) begin
            if (rd_sel[i] && count[i] != '0) begin
                bus.h_data = head[i];
            end
        end
    end
endmodule
